// File: rtl/data_reg_dut.sv
// data_reg_dut: D-type pipeline register, DEPTH stages of WIDTH bits, loads every cycle.
// Latency: DEPTH rising clk edges from data_in to data_out; the output is purely registered.
// Backpressure: none (no enable); rst low asynchronously forces every stage to RESET_VAL.
// Optional feature macro: REG_PARITY_EN adds par_out, an even-parity bit piped with the data.
module data_reg_dut #(
  parameter int unsigned            WIDTH     = 4,
  parameter int unsigned            DEPTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
`ifdef REG_PARITY_EN
  output logic [WIDTH-1:0] data_out,
  output logic             par_out
`else
  output logic [WIDTH-1:0] data_out
`endif
);

  // Stage array; index 0 is fed from data_in, index DEPTH-1 drives data_out.
  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift data through the stages; asynchronous reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RESET_VAL;
      end
    end else begin
      r_stage[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Output is the last stage directly; no combinational path from data_in.
  assign data_out = r_stage[DEPTH-1];

`ifdef REG_PARITY_EN
  // Parity is computed at the input and travels alongside its data word, so it
  // always matches ^data_out without an XOR tree on the output side.
  localparam logic RESET_PAR = ^RESET_VAL;

  logic w_par_in;
  logic r_par [DEPTH];

  assign w_par_in = ^data_in;

  // Parity sideband pipeline, same depth and reset behaviour as the data stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_par[i] <= RESET_PAR;
      end
    end else begin
      r_par[0] <= w_par_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_par[i] <= r_par[i-1];
      end
    end
  end

  assign par_out = r_par[DEPTH-1];
`endif

endmodule

// File: tb/tb_data_reg_dut.sv
// Testbench for data_reg_dut: a DEPTH=1 and a DEPTH=3 instance share clk, rst and data_in.
// Expected outputs come from a history queue of accepted inputs (newest first).
module tb_data_reg_dut;

  localparam int         W   = 4;
  localparam logic [3:0] RV  = 4'b0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = 4'b1111;
  logic [W-1:0] out1;
  logic [W-1:0] out3;
`ifdef REG_PARITY_EN
  logic         par1;
  logic         par3;
`endif

  int checks   = 0;
  int failures = 0;

  // Inputs accepted by the pipeline since the last reset, newest at index 0.
  logic [W-1:0] hist [$];

  always #5 clk = ~clk;

  data_reg_dut #(.WIDTH(W), .DEPTH(1), .RESET_VAL(RV)) u_d1 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
`ifdef REG_PARITY_EN
    .data_out (out1),
    .par_out  (par1)
`else
    .data_out (out1)
`endif
  );

  data_reg_dut #(.WIDTH(W), .DEPTH(3), .RESET_VAL(RV)) u_d3 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
`ifdef REG_PARITY_EN
    .data_out (out3),
    .par_out  (par3)
`else
    .data_out (out3)
`endif
  );

  // Reference model: every rising edge out of reset accepts data_in.
  always @(posedge clk) begin
    if (rst) begin
      hist.push_front(data_in);
      if (hist.size() > 8) void'(hist.pop_back());
    end
  end

  // Reference model: reset assertion forgets all accepted inputs.
  always @(negedge rst) hist.delete();

  // Value the model predicts after d accepted inputs of latency.
  function automatic logic [W-1:0] exp_out(input int d);
    if (hist.size() >= d) return hist[d-1];
    return RV;
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (out1 !== 4'b0000) begin failures++; $display("FAIL reset_d1_t2 got=%b want=%b", out1, 4'b0000); end
    checks++;
    if (out3 !== 4'b0000) begin failures++; $display("FAIL reset_d3_t2 got=%b want=%b", out3, 4'b0000); end
    @(negedge clk); // t=10, after the t=5 edge with rst low
    checks++;
    if (out1 !== 4'b0000) begin failures++; $display("FAIL reset_no_capture got=%b want=%b", out1, 4'b0000); end
`ifdef REG_PARITY_EN
    checks++;
    if (par1 !== 1'b0) begin failures++; $display("FAIL reset_par got=%b want=%b", par1, 1'b0); end
`endif
  endtask

  task automatic test_load_update();
    rst = 1'b1; data_in = 4'b1010;          // t=10
    @(negedge clk);                          // t=20
    checks++;
    if (out1 !== 4'b1010) begin failures++; $display("FAIL load got=%b want=%b", out1, 4'b1010); end
    checks++;
    if (out3 !== 4'b0000) begin failures++; $display("FAIL load_d3_latency got=%b want=%b", out3, 4'b0000); end
    data_in = 4'b1100;
    @(negedge clk);                          // t=30
    checks++;
    if (out1 !== 4'b1100) begin failures++; $display("FAIL update got=%b want=%b", out1, 4'b1100); end
`ifdef REG_PARITY_EN
    checks++;
    if (par1 !== 1'b0) begin failures++; $display("FAIL update_par got=%b want=%b", par1, 1'b0); end
`endif
  endtask

  task automatic test_async_reset();
    #2; rst = 1'b0;                          // t=32, between edges
    #1;                                      // t=33
    checks++;
    if (out1 !== 4'b0000) begin failures++; $display("FAIL async_reset_d1 got=%b want=%b", out1, 4'b0000); end
    checks++;
    if (out3 !== 4'b0000) begin failures++; $display("FAIL async_reset_d3 got=%b want=%b", out3, 4'b0000); end
    @(negedge clk);                          // t=40
    checks++;
    if (out1 !== 4'b0000) begin failures++; $display("FAIL reset_hold got=%b want=%b", out1, 4'b0000); end
    rst = 1'b1; data_in = 4'b0101;
    @(negedge clk);                          // t=50
    checks++;
    if (out1 !== 4'b0101) begin failures++; $display("FAIL recovery got=%b want=%b", out1, 4'b0101); end
    checks++;
    if (out3 !== 4'b0000) begin failures++; $display("FAIL recovery_d3_refill got=%b want=%b", out3, 4'b0000); end
  endtask

  task automatic test_depth3_pulse();
    // Flush with zeros, then a single-cycle 0111 pulse.
    data_in = 4'b0000;
    repeat (3) @(negedge clk);
    data_in = 4'b0111;
    @(negedge clk);
    data_in = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      logic [W-1:0] want;
      want = (k == 3) ? 4'b0111 : 4'b0000;
      checks++;
      if (out3 !== want) begin failures++; $display("FAIL d3_pulse k=%0d got=%b want=%b", k, out3, want); end
`ifdef REG_PARITY_EN
      checks++;
      if (par3 !== ^want) begin failures++; $display("FAIL d3_pulse_par k=%0d got=%b want=%b", k, par3, ^want); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_constant();
    data_in = 4'b1001;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out1 !== 4'b1001) begin failures++; $display("FAIL const_d1 k=%0d got=%b want=%b", k, out1, 4'b1001); end
      checks++;
      if (out3 !== 4'b1001) begin failures++; $display("FAIL const_d3 k=%0d got=%b want=%b", k, out3, 4'b1001); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [W-1:0] e1;
      logic [W-1:0] e3;
      e1 = exp_out(1);
      e3 = exp_out(3);
      checks++;
      if (out1 !== e1) begin failures++; $display("FAIL rand_d1 n=%0d got=%b want=%b", n, out1, e1); end
      checks++;
      if (out3 !== e3) begin failures++; $display("FAIL rand_d3 n=%0d got=%b want=%b", n, out3, e3); end
`ifdef REG_PARITY_EN
      checks++;
      if (par1 !== ^e1) begin failures++; $display("FAIL rand_par1 n=%0d got=%b want=%b", n, par1, ^e1); end
      checks++;
      if (par3 !== ^e3) begin failures++; $display("FAIL rand_par3 n=%0d got=%b want=%b", n, par3, ^e3); end
`endif
      data_in = W'($urandom);
      if ($urandom_range(15) == 0) begin
        // Mid-stream reset away from the edges, released at the next falling edge.
        #3; rst = 1'b0; data_in = W'($urandom);
        #1;
        checks++;
        if (out3 !== RV) begin failures++; $display("FAIL rand_reset n=%0d got=%b want=%b", n, out3, RV); end
        @(negedge clk);
        rst = 1'b1;
        data_in = W'($urandom);
        // The cycle that ends here saw no capture; outputs stay at reset value.
        checks++;
        if (out1 !== RV) begin failures++; $display("FAIL rand_reset_hold n=%0d got=%b want=%b", n, out1, RV); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load_update();
    test_async_reset();
    test_depth3_pulse();
    test_constant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
